// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback requesters.
// The granted write is registered onto the rf_* pins; forwarding flags cover the pending commit.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                hold,
  output logic                rf_we,
  output logic [AW-1:0]       rf_rd,
  output logic [DW-1:0]       rf_wdata,
  input  logic [AW-1:0]       rs_a,
  input  logic [AW-1:0]       rs_b,
  output logic                fwd_a_hit,
  output logic                fwd_b_hit,
  output logic [15:0]         wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic           rf_we_q, rf_we_d;
  logic [AW-1:0]  rf_rd_q, rf_rd_d;
  logic [DW-1:0]  rf_wdata_q, rf_wdata_d;
  logic [15:0]    wr_count_q, wr_count_d;

  logic           found;
  logic [PW-1:0]  g;
  logic [PW-1:0]  cand;
  logic           accept;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_data;

  // Scan from the highest index down so the candidate closest to ptr wins last.
  always_comb begin
    found = 1'b0;
    g     = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
  end

  // Gating with resetn keeps ready low for the whole reset window.
  assign accept = found & ~hold & resetn;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g == PW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[g] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    wr_count_d = wr_count_q + {15'd0, rf_we_q};
    if (accept) begin
      // r0 writes are consumed to free the requester but never reach the regfile.
      rf_we_d    = (sel_addr != '0);
      rf_rd_d    = sel_addr;
      rf_wdata_d = sel_data;
      ptr_d      = (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      wr_count_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign wr_count  = wr_count_q;
  assign fwd_a_hit = rf_we_q & (rs_a == rf_rd_q) & (rs_a != '0);
  assign fwd_b_hit = rf_we_q & (rs_b == rf_rd_q) & (rs_b != '0);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a behavioural model.
module tb_regfile_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               rf_we;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_wdata;
  logic [AW-1:0]      rs_a, rs_b;
  logic               fwd_a_hit, fwd_b_hit;
  logic [15:0]        wr_count;

  logic               v [NREQ];
  logic [AW-1:0]      a [NREQ];
  logic [DW-1:0]      d [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_valid[i]          = v[i];
    assign req_addr[i*AW +: AW]  = a[i];
    assign req_data[i*DW +: DW]  = d[i];
  end

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .hold(hold),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rs_a(rs_a), .rs_b(rs_b), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference state
  int            m_ptr = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_count = 0;
  int            last_g = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_rd = '0; m_wdata = '0; m_count = 0;
  endtask

  task automatic model_update();
    int g;
    if (!resetn) begin
      model_reset();
      last_g = -1;
      return;
    end
    g = model_grant();
    m_count = (m_count + (m_we ? 1 : 0)) % 65536;
    if (!hold && g >= 0) begin
      m_rd = a[g]; m_wdata = d[g]; m_we = (a[g] != 0);
      m_ptr = (g + 1) % NREQ; last_g = g;
    end else begin
      m_we = 0; last_g = -1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int g;
    g = model_grant();
    exp_ready = '0;
    if (resetn && !hold && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("fwd_a_hit", fwd_a_hit, m_we && rs_a == m_rd && rs_a != 0);
    chk("fwd_b_hit", fwd_b_hit, m_we && rs_b == m_rd && rs_b != 0);
    chk("wr_count", wr_count, m_count[15:0]);
  end

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    cycle();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; hold = 1'b0; rs_a = '0; rs_b = '0;
    for (int i = 0; i < NREQ; i++) begin v[i] = 1'b0; a[i] = '0; d[i] = '0; end

    // Reset: ready stays low even with a valid present
    cycle();
    v[0] = 1'b1; #1;
    chk("lit_reset_ready", req_ready, 3'b000);
    chk("lit_reset_we", rf_we, 1'b0);
    chk("lit_reset_count", wr_count, 16'd0);
    v[0] = 1'b0;
    cycle();
    resetn = 1'b1;

    // Requester 1 writes r7
    v[1] = 1'b1; a[1] = 5'd7; d[1] = 32'hDEADBEEF; rs_a = 5'd7; #1;
    chk("lit_r1_ready", req_ready, 3'b010);
    cycle(); v[1] = 1'b0; #1;
    chk("lit_r1_we", rf_we, 1'b1);
    chk("lit_r1_rd", rf_rd, 5'd7);
    chk("lit_r1_data", rf_wdata, 32'hDEADBEEF);
    chk("lit_r1_fwd", fwd_a_hit, 1'b1);
    cycle();
    chk("lit_r1_we_drop", rf_we, 1'b0);
    chk("lit_r1_count", wr_count, 16'd1);

    // All valid, round robin from ptr 0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = 32'h100 + i; end
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("lit_rr_rd", rf_rd, (c % 3) + 1);
    end
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    cycle();
    chk("lit_rr_count", wr_count, 16'd6);

    // r0 write consumed silently
    v[2] = 1'b1; a[2] = 5'd0; d[2] = 32'h1234; rs_a = 5'd0; #1;
    chk("lit_r0_ready", req_ready, 3'b100);
    cycle(); v[2] = 1'b0; a[2] = 5'd3;
    chk("lit_r0_we", rf_we, 1'b0);
    chk("lit_r0_fwd", fwd_a_hit, 1'b0);
    cycle();
    chk("lit_r0_count", wr_count, 16'd6);

    // Hold with all valid
    for (int i = 0; i < NREQ; i++) v[i] = 1'b1;
    cycle();
    hold = 1'b1; #1;
    chk("lit_hold_ready", req_ready, 3'b000);
    chk("lit_hold_pending_we", rf_we, 1'b1);
    cycle();
    chk("lit_hold_we_drop", rf_we, 1'b0);
    chk("lit_hold_count", wr_count, 16'd7);
    cycle(); cycle();
    hold = 1'b0; #1;
    chk("lit_hold_resume", req_ready, 3'b010);

    // Async reset mid-cycle with a pending write
    cycle();
    chk("lit_pre_rst_we", rf_we, 1'b1);
    #2 resetn = 1'b0; model_reset();
    #1;
    chk("lit_rst_we", rf_we, 1'b0);
    chk("lit_rst_rd", rf_rd, 5'd0);
    chk("lit_rst_data", rf_wdata, 32'd0);
    chk("lit_rst_count", wr_count, 16'd0);
    cycle();
    resetn = 1'b1; #1;
    chk("lit_rst_first_grant", req_ready, 3'b001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i || !v[i]) begin
          if (last_g == i || $urandom_range(0, 2) == 0) begin
            v[i] = 1'($urandom_range(0, 1));
            a[i] = AW'($urandom_range(0, 7));
            d[i] = $urandom;
          end
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      rs_a = AW'($urandom_range(0, 7));
      rs_b = AW'($urandom_range(0, 7));
      if (c == 1500) begin
        #2 resetn = 1'b0; model_reset();
        cycle();
        resetn = 1'b1;
      end
    end

    // Counter wrap
    hold = 1'b0;
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    do_reset();
    v[0] = 1'b1; a[0] = 5'd5; d[0] = 32'hA5A5A5A5;
    repeat (65536) cycle();
    chk("lit_wrap_ffff", wr_count, 16'hFFFF);
    v[0] = 1'b0;
    cycle();
    chk("lit_wrap_zero", wr_count, 16'h0000);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port among `NREQ` writeback requesters (ALU result, memory load, debug/host) in the multicycle CPU. Uses round-robin arbitration with a valid/ready handshake per requester. The granted write is registered into an output stage that drives the regfile `rd`/`i_data`/`we` pins directly. Also provides forwarding-hit flags for the two read ports while a registered write is waiting to commit, plus a committed-write counter.

## Interface
- `NREQ`, 3: number of write requesters (2..8).
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `clk` input 1: single clock; all state updates on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: bit i = requester i has a write pending.
- `req_addr` input NREQ*AW: requester i destination at bits [i*AW +: AW].
- `req_data` input NREQ*DW: requester i write data at bits [i*DW +: DW].
- `req_ready` output NREQ: one-hot grant; the write transfers on a rising edge where valid&ready.
- `hold` input 1: freezes arbitration (no grants).
- `rf_we` output 1: write enable to the regfile.
- `rf_rd` output AW: write address to the regfile.
- `rf_wdata` output DW: write data to the regfile.
- `rs_a`, `rs_b` input AW: regfile read addresses currently applied.
- `fwd_a_hit`, `fwd_b_hit` output 1: read port must take `rf_wdata` instead of the regfile output.
- `wr_count` output 16: number of committed writes (cycles with `rf_we`=1), mod 2^16.

## Operation
- Round-robin pointer `ptr` (0..NREQ-1) holds the highest-priority index.
  - Winner `g` = first i with `req_valid[i]`, scanning ptr, ptr+1, …, wrapping mod NREQ.
- `req_ready[g]`=1 only when `hold`=0 and some valid exists; all other ready bits are 0.
  - Ready is combinational from valid/ptr/hold and never depends on `rf_*`.
- Requesters hold valid/addr/data stable until accepted and never retract a pending valid.
- Accept edge (valid&ready):
  - `rf_rd`<=addr and `rf_wdata`<=data.
  - `rf_we`<=(addr!=0). A write to r0 is consumed but never asserts `rf_we`.
  - `ptr`<=(g+1) mod NREQ.
- Edge with no accept (no valid, or `hold`=1):
  - `rf_we`<=0.
  - `rf_rd`/`rf_wdata` keep their values.
  - `ptr` unchanged.
- `fwd_a_hit` = `rf_we` & (`rs_a`==`rf_rd`) & (`rs_a`!=0); `fwd_b_hit` is the same using `rs_b`. Both are combinational.
- `wr_count` increments on every edge where `rf_we`=1; it wraps 0xFFFF→0x0000.

## Timing
- Reset (async, immediate on `resetn` low):
  - `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, `ptr`=0, `wr_count`=0.
  - `req_ready` follows combinationally from reset state, i.e. it is all 0 while `resetn`=0.
  - An in-flight accept is discarded, and a registered write not yet committed is lost.
- Latency: accept at edge k → `rf_we` high in cycle k..k+1 → regfile updated at edge k+1.
- Throughput: one write per cycle; back-to-back accepts from different requesters are allowed.
- Fairness: with all NREQ valid continuously, each requester is granted exactly once every NREQ cycles.
- `hold` rising: grants stop in the same cycle; `rf_we` drops after the next edge (the pending write still commits).
- `hold` falling: arbitration resumes from the unchanged `ptr`.
- Same-address writes in consecutive cycles commit in grant order; the last one wins.
- Forward hits are valid only in the cycle `rf_we`=1. After the commit edge the regfile holds the value and the hit drops (unless a new write to the same address follows).

## Test plan
- Reset, then requester 1 writes r7=0xDEADBEEF:
  - `req_ready`=3'b010 in the same cycle.
  - Next cycle `rf_we`=1, `rf_rd`=7, `rf_wdata`=0xDEADBEEF, `fwd_a_hit`=1 with `rs_a`=7.
  - Next cycle `rf_we`=0 and `wr_count`=1.
- All three valid for 6 cycles, targeting r1/r2/r3: grant order 0,1,2,0,1,2; `rf_rd` sequence 1,2,3,1,2,3; `wr_count`=6.
- Requester 2 writes r0=0x1234: accepted (ready=1) but `rf_we` stays 0, `wr_count` unchanged, `fwd_*_hit`=0 with `rs_a`=0.
- `hold`=1 for 3 cycles with all valid:
  - `req_ready`=0; the previously accepted write still commits, then `rf_we`=0.
  - After release, the grant goes to the `ptr` value from before the hold.
- Assert `resetn`=0 mid-cycle with `rf_we`=1:
  - `rf_we`/`rf_rd`/`rf_wdata` go to 0 immediately, `wr_count`=0, `ptr`=0.
  - First grant after release goes to requester 0.
- Preload `wr_count` near wrap by 65535 writes, then one more write: `wr_count` reads 0x0000.
